// File: rtl/apb_bridge_param.sv
// rtl/apb_bridge_param.sv - parametrised AHB-to-APB bridge with APB3 wait states, error propagation and access timeout
module apb_bridge_param #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SLV     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                REGION_BITS = 12,
    parameter int                TIMEOUT     = 0
) (
    input  logic                      Hclk,
    input  logic                      Hreset,
    input  logic [ADDR_W-1:0]         Haddr,
    input  logic [DATA_W-1:0]         Hwdata,
    input  logic [1:0]                Htrans,
    input  logic                      Hwrite,
    input  logic                      Hreadyin,
    output logic [DATA_W-1:0]         Hrdata,
    output logic                      Hreadyout,
    output logic                      Hresp,
    output logic [ADDR_W-1:0]         Paddr,
    output logic [DATA_W-1:0]         Pwdata,
    output logic                      Pwrite,
    output logic                      Penable,
    output logic [NUM_SLV-1:0]        Pselx,
    input  logic [NUM_SLV*DATA_W-1:0] Prdata,
    input  logic [NUM_SLV-1:0]        Pready,
    input  logic [NUM_SLV-1:0]        Pslverr
);

    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        to_cnt;
    logic [ADDR_W-1:0]  offset;
    logic               in_range;
    logic               accept;
    logic               sel_ready;
    logic               sel_err;
    logic               timed_out;
    logic [DATA_W-1:0]  sel_rdata;
    logic               unused_htrans0;

    assign unused_htrans0 = Htrans[0];

    assign accept   = ((state == S_IDLE) || (state == S_ERR2)) && Hreadyin && Htrans[1];
    assign offset   = Haddr - BASE_ADDR;
    assign in_range = (Haddr >= BASE_ADDR) && ((offset >> REGION_BITS) < ADDR_W'(NUM_SLV));

    // Count reaches TIMEOUT-1 on the last allowed ACCESS cycle, so exactly TIMEOUT cycles are spent
    assign timed_out = (TIMEOUT > 0) && (to_cnt == 32'(TIMEOUT - 1));

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = Pready[i];
                sel_err   = Pslverr[i];
                sel_rdata = Prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR2: begin
                if (accept) begin
                    state_nxt = in_range ? S_WAIT : S_ERR1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT:  state_nxt = S_SETUP;
            S_SETUP: state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (sel_ready) begin
                    state_nxt = sel_err ? S_ERR1 : S_IDLE;
                end else if (timed_out) begin
                    state_nxt = S_ERR1;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            idx_q  <= '0;
            Paddr  <= '0;
            Pwrite <= 1'b0;
            Pwdata <= '0;
            Hrdata <= '0;
            to_cnt <= '0;
        end else begin
            // Out-of-range requests never reach APB, so the APB address lines stay quiet for them
            if (accept && in_range) begin
                Paddr  <= Haddr;
                Pwrite <= Hwrite;
                idx_q  <= IDX_W'(offset >> REGION_BITS);
            end
            if ((state == S_WAIT) && Pwrite) begin
                Pwdata <= Hwdata;
            end
            if (state == S_WAIT) begin
                to_cnt <= '0;
            end else if ((state == S_ACCESS) && !sel_ready) begin
                to_cnt <= to_cnt + 32'd1;
            end
            if ((state == S_ACCESS) && sel_ready && !sel_err && !Pwrite) begin
                Hrdata <= sel_rdata;
            end
        end
    end

    assign Hreadyout = (state == S_IDLE) || (state == S_ERR2);
    assign Hresp     = (state == S_ERR1) || (state == S_ERR2);
    assign Penable   = (state == S_ACCESS);

    always_comb begin
        Pselx = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            Pselx[i] = ((state == S_SETUP) || (state == S_ACCESS)) && (idx_q == IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_apb_bridge_param.sv
// tb/tb_apb_bridge_param.sv - randomized self-checking bench for apb_bridge_param
module tb_apb_bridge_param;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          TO   = 4;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic        Hreadyin;
    logic [31:0] Hrdata;
    logic        Hreadyout;
    logic        Hresp;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pwrite;
    logic        Penable;
    logic [2:0]  Pselx;
    logic [95:0] Prdata;
    logic [2:0]  Pready;
    logic [2:0]  Pslverr;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hrdata = 32'h0;

    apb_bridge_param #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .BASE_ADDR(BASE),
        .REGION_BITS(12), .TIMEOUT(TO)
    ) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Haddr(Haddr), .Hwdata(Hwdata),
        .Htrans(Htrans), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Hrdata(Hrdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
        .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite), .Penable(Penable),
        .Pselx(Pselx), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the bridge ready; ends at the negedge where Hreadyout is high again
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int stall, input logic serr);
        logic [31:0] off;
        logic [31:0] rd [3];
        int          idx;
        bit          inr;
        bit          exp_err;
        int          exp_low;
        int          exp_acc;
        int          low;
        int          psel_cyc;
        int          resp_low;
        int          acc;
        off = addr - BASE;
        idx = int'(off >> 12);
        inr = (addr >= BASE) && (idx < 3);
        for (int i = 0; i < 3; i++) begin
            rd[i] = $urandom;
            Prdata[i*32 +: 32] = rd[i];
        end
        chk("accept_ready", Hreadyout, 1'b1);
        Haddr    = addr;
        Hwrite   = wr;
        Htrans   = 2'b10;
        Hreadyin = 1'b1;
        Hwdata   = $urandom;
        @(posedge Hclk);
        @(negedge Hclk);
        Htrans = 2'b00;
        Hwdata = wdata;
        Haddr  = $urandom;
        Hwrite = $urandom_range(0, 1);
        low = 0; psel_cyc = 0; resp_low = 0; acc = 0;
        while (Hreadyout !== 1'b1 && low < 40) begin
            low++;
            if (Hresp === 1'b1) resp_low++;
            if (Pselx !== 3'b000) begin
                psel_cyc++;
                chk("pselx_onehot", Pselx, 64'd1 << idx);
            end
            if (Penable === 1'b1) begin
                chk("paddr", Paddr, addr);
                chk("pwrite", Pwrite, wr);
                if (wr) chk("pwdata", Pwdata, wdata);
                if (acc >= stall) begin
                    Pready  = 3'b001 << idx;
                    Pslverr = serr ? 3'b111 : ~(3'b001 << idx);
                end else begin
                    Pready  = 3'b000;
                    Pslverr = 3'b111;
                end
                acc++;
            end else begin
                Pready  = 3'b000;
                Pslverr = 3'b000;
            end
            @(negedge Hclk);
        end
        Pready  = 3'b000;
        Pslverr = 3'b000;

        if (!inr) begin
            exp_acc = 0; exp_err = 1'b1; exp_low = 1;
        end else if (stall >= TO) begin
            exp_acc = TO; exp_err = 1'b1; exp_low = 2 + TO + 1;
        end else begin
            exp_acc = stall + 1; exp_err = serr; exp_low = 2 + exp_acc + (serr ? 1 : 0);
        end
        if (inr && !wr && !exp_err) exp_hrdata = rd[idx];

        chk("hready_low_cycles", low, exp_low);
        chk("psel_cycles", psel_cyc, inr ? exp_acc + 1 : 0);
        chk("access_cycles", acc, exp_acc);
        chk("hresp_low_cycles", resp_low, exp_err ? 1 : 0);
        chk("hresp_done", Hresp, exp_err);
        chk("hrdata", Hrdata, exp_hrdata);
    endtask

    task automatic idle_cycle();
        Htrans = 2'b00;
        @(negedge Hclk);
        chk("idle_hresp", Hresp, 1'b0);
        chk("idle_ready", Hreadyout, 1'b1);
        chk("idle_psel", Pselx, 3'b000);
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        int          w;
        Hreset = 1'b0; Haddr = '0; Hwdata = '0; Htrans = 2'b00; Hwrite = 1'b0;
        Hreadyin = 1'b1; Prdata = '0; Pready = '0; Pslverr = '0;
        @(negedge Hclk);
        @(negedge Hclk);
        chk("rst_hreadyout", Hreadyout, 1'b1);
        chk("rst_hresp", Hresp, 1'b0);
        chk("rst_hrdata", Hrdata, 32'h0);
        chk("rst_paddr", Paddr, 32'h0);
        chk("rst_pwdata", Pwdata, 32'h0);
        chk("rst_pctrl", {Pwrite, Penable, Pselx}, 5'b0);
        Hreset = 1'b1;
        @(negedge Hclk);

        // BUSY, and NONSEQ without Hreadyin, must both be ignored
        Haddr = 32'h8000_0000; Htrans = 2'b01;
        @(negedge Hclk);
        chk("busy_ignored", {Hreadyout, Pselx}, 4'b1000);
        Htrans = 2'b10; Hreadyin = 1'b0;
        @(negedge Hclk);
        @(negedge Hclk);
        chk("noready_ignored", {Hreadyout, Hresp, Pselx}, 5'b10000);
        Hreadyin = 1'b1; Htrans = 2'b00;
        @(negedge Hclk);

        do_xfer(32'h8000_2010, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
        idle_cycle();
        do_xfer(32'h8000_0000, 1'b0, 32'h0, 2, 1'b0);
        idle_cycle();
        do_xfer(32'h8000_1008, 1'b0, 32'h0, 0, 1'b1);
        idle_cycle();
        do_xfer(32'h8000_3000, 1'b0, 32'h0, 0, 1'b0);
        idle_cycle();
        do_xfer(32'h7FFF_FFFC, 1'b1, 32'h1111_2222, 0, 1'b0);
        idle_cycle();
        do_xfer(32'h8000_1100, 1'b0, 32'h0, 10, 1'b0);
        do_xfer(32'h8000_2004, 1'b1, 32'hCAFE_F00D, 0, 1'b0);
        idle_cycle();
        do_xfer(32'h8000_0ffc, 1'b0, 32'h0, 3, 1'b0);
        do_xfer(32'h8000_2ffc, 1'b0, 32'h0, 0, 1'b0);
        idle_cycle();

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7)       a = BASE + (32'($urandom_range(0, 2)) << 12) + (32'($urandom_range(0, 1023)) << 2);
            else if (kind < 9)  a = BASE + 32'h3000 + (32'($urandom_range(0, 1023)) << 2);
            else                a = BASE - (32'($urandom_range(1, 256)) << 2);
            do_xfer(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5),
                    1'($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        // Asynchronous reset while an ACCESS is stalled
        Haddr = 32'h8000_1004; Hwrite = 1'b0; Htrans = 2'b10; Pready = '0;
        @(posedge Hclk);
        @(negedge Hclk);
        Htrans = 2'b00;
        w = 0;
        while (Penable !== 1'b1 && w < 10) begin
            w++;
            @(negedge Hclk);
        end
        chk("rst_mid_in_access", Penable, 1'b1);
        Hreset = 1'b0;
        #1;
        chk("rst_mid_pselx", Pselx, 3'b000);
        chk("rst_mid_penable", Penable, 1'b0);
        chk("rst_mid_hreadyout", Hreadyout, 1'b1);
        chk("rst_mid_hresp", Hresp, 1'b0);
        chk("rst_mid_hrdata", Hrdata, 32'h0);
        chk("rst_mid_paddr", Paddr, 32'h0);
        exp_hrdata = 32'h0;
        @(negedge Hclk);
        Hreset = 1'b1;
        @(negedge Hclk);
        do_xfer(32'h8000_1004, 1'b0, 32'h0, 0, 1'b0);
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_bridge_param.md
Name: apb_bridge_param

Overview:
- Parametrised AHB-to-APB bridge, the next generation of the fixed 3-slave bridge.
- Sits between the AHB interconnect and an APB peripheral cluster of NUM_SLV slaves.
- Adds APB3 wait states (Pready), error propagation (Pslverr → Hresp), out-of-range decode errors and an optional access timeout.
- Single clock domain; one outstanding transfer at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NUM_SLV, 3, number of APB slaves (1..16).
- BASE_ADDR, 32'h8000_0000, start of the APB window.
- REGION_BITS, 12, log2 of the address span per slave.
- TIMEOUT, 0, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- Hclk  input  1  clock; all logic on the rising edge.
- Hreset  input  1  asynchronous, active-low reset.
- Haddr  input  ADDR_W  AHB address.
- Hwdata  input  DATA_W  AHB write data, valid in the data phase.
- Htrans  input  2  AHB transfer type; NONSEQ=2, SEQ=3.
- Hwrite  input  1  AHB direction; 1 = write.
- Hreadyin  input  1  AHB bus ready.
- Hrdata  output  DATA_W  read data, registered.
- Hreadyout  output  1  bridge ready.
- Hresp  output  1  1 = ERROR response.
- Paddr  output  ADDR_W  APB address.
- Pwdata  output  DATA_W  APB write data.
- Pwrite  output  1  APB direction.
- Penable  output  1  APB enable.
- Pselx  output  NUM_SLV  one-hot slave select.
- Prdata  input  NUM_SLV*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- Pready  input  NUM_SLV  per-slave ready.
- Pslverr  input  NUM_SLV  per-slave error.

Behaviour:
- Reset (Hreset=0, asynchronous, effective at any time including mid-transfer):
  - state IDLE; Hreadyout=1.
  - Hresp, Hrdata, Paddr, Pwdata, Pwrite, Penable and Pselx all 0.
  - timeout counter 0.
  - An APB transfer in flight is abandoned.
- Accept condition: state is IDLE or ERR2, and Hreadyin=1, and Htrans[1]=1. On accept, latch Haddr and Hwrite, and compute idx = (Haddr - BASE_ADDR) >> REGION_BITS.
- Decode: in range iff Haddr >= BASE_ADDR and idx < NUM_SLV. Otherwise go straight to ERR1; no APB cycle is issued.
- States:
  - IDLE: Hreadyout=1, Hresp=0, Pselx=0, Penable=0.
  - WAIT: Hreadyout=0. Captures Hwdata into Pwdata at the end of the cycle (writes only; reads leave Pwdata unchanged). → SETUP.
  - SETUP: Pselx[idx]=1, Penable=0; Paddr, Pwrite stable. → ACCESS.
  - ACCESS: Pselx[idx]=1, Penable=1. Sample Pready[idx] and Pslverr[idx]:
    - Pready=1, Pslverr=0: Hrdata ← Prdata slice idx (reads only; writes leave Hrdata unchanged). → IDLE.
    - Pready=1, Pslverr=1: → ERR1.
    - Pready=0: stay; increment the timeout counter. If TIMEOUT>0 and the count reaches TIMEOUT-1 → ERR1 (Pselx and Penable drop next cycle).
  - ERR1: Hresp=1, Hreadyout=0, Pselx=0. → ERR2.
  - ERR2: Hresp=1, Hreadyout=1. May accept a new transfer, same as IDLE; otherwise → IDLE.
- Hreadyout and Hresp are decoded from the registered state (glitch-free).
- Latency, read with Pready tied high: address phase at cycle T; WAIT T+1; SETUP T+2; ACCESS T+3; Hreadyout=1 with valid Hrdata at T+4.
  - Each Pready=0 cycle adds 1.
  - Writes have the same timing.
- Back-to-back: a transfer accepted in the IDLE cycle that completes the previous transfer proceeds to WAIT with no gap.
- Htrans IDLE(0) or BUSY(1) in IDLE: no action.
- Htrans is ignored in all non-accepting states.
- Pselx is never multi-hot. Pselx and Penable both drop in the cycle after ACCESS completes.
- Timeout counter clears on entry to SETUP.

Test Plan:
- Reset mid-ACCESS (Pready held 0), assert Hreset=0 → outputs go to reset values immediately, Pselx=0; after release, a read of 0x8000_1004 runs normally.
- Write Haddr=0x8000_2010, Hwdata=0xDEADBEEF, Pready=1 → Pselx=3'b100 for SETUP and ACCESS cycles, Paddr=0x8000_2010, Pwdata=0xDEADBEEF, Pwrite=1; Hreadyout low 3 cycles, high at T+4.
- Read 0x8000_0000 with slave0 Prdata=0x1234_5678 and Pready low for 2 ACCESS cycles → Hreadyout high at T+6, Hrdata=0x1234_5678, Hresp=0.
- Slave1 read returns Pslverr=1 → ERR1 (Hresp=1, Hreadyout=0), then ERR2 (Hresp=1, Hreadyout=1), then IDLE.
- Address 0x8000_3000 (idx=3 ≥ NUM_SLV) → no Pselx activity; two-cycle error response starting T+1.
- TIMEOUT=4, Pready stuck at 0 → exactly 4 ACCESS cycles, then ERR1/ERR2; followed by a back-to-back valid write accepted in ERR2 completing without a gap.
